// File: rtl/ps2_arrow_decoder_if.sv
// Byte-stream in / direction-levels out bundle between the PS/2 receiver
// and the arrow decoder.
interface ps2_arrow_decoder_if;
  logic [7:0] code;
  logic       code_valid;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       dir_change;
  logic       timeout;

  modport master (
    output code, code_valid,
    input  up, down, left, right, dir_change, timeout
  );

  modport slave (
    input  code, code_valid,
    output up, down, left, right, dir_change, timeout
  );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// Scan-code set 2 prefix tracker turning arrow/WASD make/break bytes into a
// one-hot "last pressed, still held" direction, with a stuck-key watchdog.
module ps2_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int ENABLE_WASD    = 1
) (
  input  logic CLOCK_50,
  input  logic reset,
  ps2_arrow_decoder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  // Direction bit order everywhere: [0]=up [1]=down [2]=left [3]=right.
  state_t          r_state;
  logic [2:0]      r_skip;
  logic [3:0]      r_held;
  logic [3:0]      r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_dir_change;
  logic            r_timeout;

  logic            w_ext;
  logic            w_prefix;
  logic            w_make;
  logic            w_brk;
  logic [3:0]      w_key;
  logic [3:0]      w_held_nx;
  logic [3:0]      w_last_nx;

  function automatic logic [3:0] prio(input logic [3:0] h);
    if      (h[0]) prio = 4'b0001;
    else if (h[1]) prio = 4'b0010;
    else if (h[2]) prio = 4'b0100;
    else if (h[3]) prio = 4'b1000;
    else           prio = 4'b0000;
  endfunction

  always_comb begin
    w_ext    = (r_state == EXT) || (r_state == EXT_BRK);
    w_prefix = (bus.code == 8'hE0) || (bus.code == 8'hF0) || (bus.code == 8'hE1);
    w_key    = 4'b0000;
    if (w_ext) begin
      case (bus.code)
        8'h75:   w_key = 4'b0001;
        8'h72:   w_key = 4'b0010;
        8'h6B:   w_key = 4'b0100;
        8'h74:   w_key = 4'b1000;
        default: w_key = 4'b0000;
      endcase
    end else if (ENABLE_WASD != 0) begin
      case (bus.code)
        8'h1D:   w_key = 4'b0001;
        8'h1B:   w_key = 4'b0010;
        8'h1C:   w_key = 4'b0100;
        8'h23:   w_key = 4'b1000;
        default: w_key = 4'b0000;
      endcase
    end

    w_make = bus.code_valid &&
             (((r_state == IDLE) && !w_prefix) ||
              ((r_state == EXT) && (bus.code != 8'hE0) && (bus.code != 8'hF0)));
    w_brk  = bus.code_valid && ((r_state == BRK) || (r_state == EXT_BRK));

    w_held_nx = r_held;
    w_last_nx = r_last;
    if (w_make && (w_key != 4'b0000)) begin
      w_held_nx = r_held | w_key;
      // A repeat of an already-held key must not steal focus back.
      if ((r_held & w_key) == 4'b0000) w_last_nx = w_key;
    end else if (w_brk && (w_key != 4'b0000)) begin
      w_held_nx = r_held & ~w_key;
      if (w_key == r_last) w_last_nx = prio(w_held_nx);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_skip       <= 3'd0;
      r_held       <= 4'b0000;
      r_last       <= 4'b0000;
      r_cnt        <= '0;
      r_dir_change <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_dir_change <= 1'b0;
      r_timeout    <= 1'b0;
      if (bus.code_valid) begin
        r_cnt        <= '0;
        r_held       <= w_held_nx;
        r_last       <= w_last_nx;
        r_dir_change <= (w_last_nx != r_last);
        case (r_state)
          IDLE: begin
            if      (bus.code == 8'hE0) r_state <= EXT;
            else if (bus.code == 8'hF0) r_state <= BRK;
            else if (bus.code == 8'hE1) begin
              r_state <= SKIP;
              r_skip  <= 3'd7;
            end
          end
          EXT: begin
            if      (bus.code == 8'hF0) r_state <= EXT_BRK;
            else if (bus.code != 8'hE0) r_state <= IDLE;
          end
          BRK, EXT_BRK: r_state <= IDLE;
          SKIP: begin
            r_skip <= r_skip - 3'd1;
            if (r_skip == 3'd1) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_held == 4'b0000) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        // While anything is held, r_last is non-zero, so the release is a change.
        r_held       <= 4'b0000;
        r_last       <= 4'b0000;
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_timeout    <= 1'b1;
        r_dir_change <= (r_last != 4'b0000);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.up         = r_last[0];
  assign bus.down       = r_last[1];
  assign bus.left       = r_last[2];
  assign bus.right      = r_last[3];
  assign bus.dir_change = r_dir_change;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench: a byte/expectation table for the main decode paths plus
// hand sequences for WASD disable, watchdog timing and reset mid-prefix.
module tb_ps2_arrow_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ps2_arrow_decoder_if bus0 ();
  ps2_arrow_decoder_if bus1 ();
  assign bus0.code = code;
  assign bus0.code_valid = code_valid;
  assign bus1.code = code;
  assign bus1.code_valid = code_valid;

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(100), .ENABLE_WASD(1)) dut0 (
    .CLOCK_50(clk), .reset(rst_n), .bus(bus0));
  ps2_arrow_decoder #(.TIMEOUT_CYCLES(100), .ENABLE_WASD(0)) dut1 (
    .CLOCK_50(clk), .reset(rst_n), .bus(bus1));

  // dir nibble = {right, left, down, up}
  typedef struct {
    logic       rst;
    logic [7:0] code;
    logic [3:0] dir;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] dir0();
    return {bus0.right, bus0.left, bus0.down, bus0.up};
  endfunction
  function automatic logic [3:0] dir1();
    return {bus1.right, bus1.left, bus1.down, bus1.up};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; leaves us at the negedge after the sampling edge.
  task automatic step(input logic [7:0] b);
    code = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [7:0] c, input logic [3:0] d, input logic ch);
    vec_t v;
    v.rst = r; v.code = c; v.dir = d; v.chg = ch;
    vecs.push_back(v);
  endtask

  initial begin
    int tk;
    // make/break right
    add(1, 8'hE0, 4'h0, 0); add(0, 8'h74, 4'h8, 1);
    add(0, 8'hE0, 4'h8, 0); add(0, 8'hF0, 4'h8, 0); add(0, 8'h74, 4'h0, 1);
    // rollover up + left
    add(1, 8'hE0, 4'h0, 0); add(0, 8'h75, 4'h1, 1);
    add(0, 8'hE0, 4'h1, 0); add(0, 8'h6B, 4'h4, 1);
    add(0, 8'hE0, 4'h4, 0); add(0, 8'hF0, 4'h4, 0); add(0, 8'h6B, 4'h1, 1);
    add(0, 8'hE0, 4'h1, 0); add(0, 8'hF0, 4'h1, 0); add(0, 8'h75, 4'h0, 1);
    // typematic down x5
    add(1, 8'hE0, 4'h0, 0); add(0, 8'h72, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      add(0, 8'hE0, 4'h2, 0); add(0, 8'h72, 4'h2, 0);
    end
    add(0, 8'hE0, 4'h2, 0); add(0, 8'hF0, 4'h2, 0); add(0, 8'h72, 4'h0, 1);
    // WASD alias shares held bit with arrow
    add(1, 8'h1D, 4'h1, 1);
    add(0, 8'hE0, 4'h1, 0); add(0, 8'hF0, 4'h1, 0); add(0, 8'h75, 4'h0, 1);
    // pause sequence then D
    add(1, 8'hE1, 4'h0, 0); add(0, 8'h14, 4'h0, 0); add(0, 8'h77, 4'h0, 0);
    add(0, 8'hE1, 4'h0, 0); add(0, 8'hF0, 4'h0, 0); add(0, 8'h14, 4'h0, 0);
    add(0, 8'hF0, 4'h0, 0); add(0, 8'h77, 4'h0, 0); add(0, 8'h23, 4'h8, 1);
    // break of a key not held, then real break
    add(0, 8'hF0, 4'h8, 0); add(0, 8'h1C, 4'h8, 0);
    add(0, 8'hF0, 4'h8, 0); add(0, 8'h23, 4'h0, 1);
    // priority fallback: W, S, D held, release D -> up wins over down
    add(1, 8'h1D, 4'h1, 1); add(0, 8'h1B, 4'h2, 1); add(0, 8'h23, 4'h8, 1);
    add(0, 8'hF0, 4'h8, 0); add(0, 8'h23, 4'h1, 1);
    add(0, 8'hF0, 4'h1, 0); add(0, 8'h1D, 4'h2, 1);
    add(0, 8'hF0, 4'h2, 0); add(0, 8'h1B, 4'h0, 1);

    do_reset();
    chk("reset_dir", dir0(), 0);
    chk("reset_chg", bus0.dir_change, 0);
    chk("reset_timeout", bus0.timeout, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].code);
      chk($sformatf("vec%0d_dir", i), dir0(), vecs[i].dir);
      chk($sformatf("vec%0d_chg", i), bus0.dir_change, vecs[i].chg);
    end

    // WASD disabled: W ignored, arrows still decode
    do_reset();
    step(8'h1D);
    chk("nowasd_dir", dir1(), 0);
    chk("nowasd_chg", bus1.dir_change, 0);
    step(8'hE0);
    step(8'h75);
    chk("nowasd_arrow_dir", dir1(), 4'h1);
    chk("nowasd_arrow_chg", bus1.dir_change, 1);

    // watchdog: timeout 100 edges after the sampling edge of 74
    do_reset();
    step(8'hE0);
    step(8'h74);
    tk = -1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (tk < 0 && bus0.timeout) tk = k;
      if (k == 99)  chk("wd_right_before", bus0.right, 1);
      if (k == 100) begin
        chk("wd_right_after", bus0.right, 0);
        chk("wd_chg", bus0.dir_change, 1);
      end
      if (k == 101) chk("wd_pulse_single", bus0.timeout, 0);
    end
    chk("wd_cycle", tk, 100);

    // code_valid on the expiry cycle wins and restarts the count
    do_reset();
    step(8'hE0);
    step(8'h74);
    for (int k = 1; k <= 99; k++) @(negedge clk);
    step(8'h00);
    chk("wd_collide_timeout", bus0.timeout, 0);
    chk("wd_collide_right", bus0.right, 1);
    tk = -1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (tk < 0 && bus0.timeout) tk = k;
    end
    chk("wd_restart_cycle", tk, 100);

    // reset after a lone E0 discards the prefix
    do_reset();
    step(8'hE0);
    do_reset();
    step(8'h74);
    chk("rst_prefix_dir", dir0(), 0);
    chk("rst_prefix_chg", bus0.dir_change, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
